calendar_rtc: RTL and testbench
===============================

# calendar_rtc

Parametrised real-time calendar counter: advances second/minute/hour/day/month/year and day-of-week from a free-running clock, with a full Gregorian leap-year rule, a validated set handshake, run/hold control and carry pulses. It is the timekeeping source for the clock display and alarm logic, replacing the fixed one-tick-per-edge counter with a prescaled, loadable one.

## Interface
- TICK_DIV, 1: secclk edges per second; legal values ≥ 1.
- RESET_YEAR, 2023: year loaded on reset, 1..9999.
- RESET_MONTH, 5: month loaded on reset, 1..12.
- RESET_DAY, 9: day loaded on reset; must be valid for RESET_MONTH/RESET_YEAR.
- RESET_WEEK, 2: day-of-week loaded on reset; 1 = Monday … 7 = Sunday.
- secclk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = time advances; 0 = prescaler and all fields hold.
- set_valid  in  1  request to load all set_* fields.
- set_year/set_month/set_day  in  16/4/5  requested date.
- set_hour/set_minute/set_second  in  5/6/6  requested time.
- set_week  in  3  requested day-of-week, 1..7.
- set_ack  out  1  one-cycle pulse: set accepted.
- set_err  out  1  one-cycle pulse: set rejected, state unchanged.
- year/month/day  out  16/4/5  current date, month and day 1-based.
- hour/minute/second  out  5/6/6  current time, 0-based.
- week  out  3  current day-of-week, 1..7.
- sec_pulse/min_pulse/day_pulse  out  1  one-cycle carry strobes.
- alarm  out  1  present only with CALENDAR_RTC_ALARM_EN.
- alarm_hour/alarm_minute  in  5/6  present only with CALENDAR_RTC_ALARM_EN.

## Operation
- Prescaler counts 0..TICK_DIV-1 while run=1; the edge at which it equals TICK_DIV-1 (every edge if TICK_DIV=1) is a second tick; it then returns to 0.
- On a second tick: second+1; at 59 → 0 and minute+1; at 59 → 0 and hour+1; at 23 → 0, day+1, week+1 (7 → 1); day past days_in_month → 1 and month+1; month 12 → 1 and year+1; year 9999 → 1. The full ripple completes on that single edge; outputs never hold out-of-range values (no 60, 24, day 32, week 8).
- days_in_month: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if leap, else 28. Leap = (year mod 4 = 0 and year mod 100 ≠ 0) or year mod 400 = 0.
- sec_pulse on every second tick; min_pulse when second wraps; day_pulse when hour wraps.
- Set: set_valid=1 sampled at an edge. Valid iff year 1..9999, month 1..12, day 1..days_in_month(set_year,set_month), hour ≤ 23, minute ≤ 59, second ≤ 59, week 1..7. Valid → all fields loaded at that edge, prescaler cleared, set_ack=1 for the following cycle. Invalid → nothing changes, set_err=1 for the following cycle. Accepted regardless of run.
- Set and second tick on the same edge: set wins; no tick applied, no carry pulses.
- run=0: prescaler frozen (not cleared); resumes the count on run=1.

## Timing
- Reset (async assert, synchronous-safe release): year/month/day/week = RESET_* parameters; hour, minute, second, prescaler = 0; set_ack, set_err, all pulses, alarm = 0.
- All outputs registered; new values visible one cycle after the ticking/setting edge; set_ack/set_err and carry pulses are high exactly one cycle.
- Reset mid-operation (including during set_valid) aborts everything; no ack/err is emitted.
- set_valid held high for N cycles produces N independent set attempts.

## Configuration
- CALENDAR_RTC_ALARM_EN defined: alarm ports exist; alarm pulses one cycle when a second tick lands hour:minute:second on alarm_hour:alarm_minute:00 (a set to that time does not trigger). Out-of-range alarm inputs never match.
- Not defined: alarm ports and compare logic absent; all other behaviour identical.

## Test plan
- Reset with defaults, TICK_DIV=1 -> 2023-05-09 00:00:00 week 2; after 1 edge second=1, sec_pulse=1.
- Set 2023-12-31 23:59:59 week 7, one tick -> 2024-01-01 00:00:00 week 1, set_ack then min_pulse and day_pulse once.
- Leap: ticks past 2024-02-28 23:59:59 -> 02-29; 2100-02-28 -> 03-01; 2000-02-28 -> 02-29.
- Set day 29 month 2 year 2023 -> set_err, state unchanged; set hour 24 -> set_err.
- TICK_DIV=4, run toggled low for 3 cycles mid-count -> second advances every 4 running edges only; set coincident with tick -> set value, no sec_pulse.
- With CALENDAR_RTC_ALARM_EN, alarm 07:30 -> alarm pulses exactly once at 07:30:00 tick.

Source files
------------

// File: rtl/calendar_rtc_if.sv
// calendar_rtc_if: groups the run/set handshake and calendar outputs of calendar_rtc.
//   master : drives run, set_valid, set_* (and alarm_hour/alarm_minute); observes the rest
//   slave  : the RTC itself
// The alarm signals exist only when CALENDAR_RTC_ALARM_EN is defined.
interface calendar_rtc_if;
  logic        run;
  logic        set_valid;
  logic [15:0] set_year;
  logic [3:0]  set_month;
  logic [4:0]  set_day;
  logic [4:0]  set_hour;
  logic [5:0]  set_minute;
  logic [5:0]  set_second;
  logic [2:0]  set_week;
  logic        set_ack;
  logic        set_err;
  logic [15:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic [2:0]  week;
  logic        sec_pulse;
  logic        min_pulse;
  logic        day_pulse;
`ifdef CALENDAR_RTC_ALARM_EN
  logic        alarm;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_minute;
`endif

  modport master (
    output run, set_valid, set_year, set_month, set_day, set_hour, set_minute, set_second, set_week,
`ifdef CALENDAR_RTC_ALARM_EN
    output alarm_hour, alarm_minute,
    input  alarm,
`endif
    input  set_ack, set_err, year, month, day, hour, minute, second, week,
    input  sec_pulse, min_pulse, day_pulse
  );

  modport slave (
    input  run, set_valid, set_year, set_month, set_day, set_hour, set_minute, set_second, set_week,
`ifdef CALENDAR_RTC_ALARM_EN
    input  alarm_hour, alarm_minute,
    output alarm,
`endif
    output set_ack, set_err, year, month, day, hour, minute, second, week,
    output sec_pulse, min_pulse, day_pulse
  );
endinterface

// File: rtl/calendar_rtc.sv
// calendar_rtc: prescaled Gregorian calendar/time counter with validated set handshake.
// Ports:
//   secclk : clock, all state changes on its rising edge
//   rst    : asynchronous active-high reset
//   bus    : calendar_rtc_if.slave -- run, set_valid/set_* in; set_ack/set_err,
//            year..week, sec/min/day carry pulses out (all registered)
// Optional feature: define CALENDAR_RTC_ALARM_EN to add alarm_hour/alarm_minute
// inputs and a one-cycle alarm pulse when a tick lands on alarm_hour:alarm_minute:00.
module calendar_rtc #(
  parameter int TICK_DIV    = 1,
  parameter int RESET_YEAR  = 2023,
  parameter int RESET_MONTH = 5,
  parameter int RESET_DAY   = 9,
  parameter int RESET_WEEK  = 2
) (
  input logic           secclk,
  input logic           rst,
  calendar_rtc_if.slave bus
);
  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  function automatic logic is_leap(input logic [15:0] y);
    return ((y[1:0] == 2'b00) && ((y % 16'd100) != 16'd0)) || ((y % 16'd400) == 16'd0);
  endfunction

  function automatic logic [4:0] dim(input logic [15:0] y, input logic [3:0] m);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = is_leap(y) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  logic [PW-1:0] presc;
  logic [15:0]   year_q, n_year;
  logic [3:0]    month_q, n_month;
  logic [4:0]    day_q, n_day, hour_q, n_hour;
  logic [5:0]    min_q, n_min, sec_q, n_sec;
  logic [2:0]    week_q, n_week;
  logic          ack_q, err_q, sec_p, min_p, day_p;
  logic          tick, set_ok, min_wrap, day_wrap;

  assign tick     = bus.run && (presc == PMAX);
  assign min_wrap = (sec_q == 6'd59);
  assign day_wrap = min_wrap && (min_q == 6'd59) && (hour_q == 5'd23);

  // Day-of-month bound depends on the requested year/month, not the current date.
  assign set_ok = (bus.set_year   != 16'd0) && (bus.set_year  <= 16'd9999) &&
                  (bus.set_month  != 4'd0)  && (bus.set_month <= 4'd12)    &&
                  (bus.set_day    != 5'd0)  && (bus.set_day <= dim(bus.set_year, bus.set_month)) &&
                  (bus.set_hour   <= 5'd23) && (bus.set_minute <= 6'd59)   &&
                  (bus.set_second <= 6'd59) && (bus.set_week != 3'd0)      &&
                  (bus.set_week   <= 3'd7);

  // Full ripple of one second, evaluated every cycle; only committed on a tick.
  always_comb begin
    n_sec   = sec_q + 6'd1;
    n_min   = min_q;
    n_hour  = hour_q;
    n_day   = day_q;
    n_month = month_q;
    n_year  = year_q;
    n_week  = week_q;
    if (sec_q == 6'd59) begin
      n_sec = 6'd0;
      n_min = min_q + 6'd1;
      if (min_q == 6'd59) begin
        n_min  = 6'd0;
        n_hour = hour_q + 5'd1;
        if (hour_q == 5'd23) begin
          n_hour = 5'd0;
          n_week = (week_q == 3'd7) ? 3'd1 : week_q + 3'd1;
          n_day  = day_q + 5'd1;
          if (day_q == dim(year_q, month_q)) begin
            n_day   = 5'd1;
            n_month = month_q + 4'd1;
            if (month_q == 4'd12) begin
              n_month = 4'd1;
              n_year  = (year_q == 16'd9999) ? 16'd1 : year_q + 16'd1;
            end
          end
        end
      end
    end
  end

`ifdef CALENDAR_RTC_ALARM_EN
  logic alarm_q, alarm_hit;
  // n_* are always in range, so out-of-range alarm inputs can never match.
  assign alarm_hit = (n_hour == bus.alarm_hour) && (n_min == bus.alarm_minute) && (n_sec == 6'd0);
  assign bus.alarm = alarm_q;
`endif

  always_ff @(posedge secclk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      year_q  <= 16'(RESET_YEAR);
      month_q <= 4'(RESET_MONTH);
      day_q   <= 5'(RESET_DAY);
      week_q  <= 3'(RESET_WEEK);
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      sec_p   <= 1'b0;
      min_p   <= 1'b0;
      day_p   <= 1'b0;
`ifdef CALENDAR_RTC_ALARM_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      sec_p <= 1'b0;
      min_p <= 1'b0;
      day_p <= 1'b0;
`ifdef CALENDAR_RTC_ALARM_EN
      alarm_q <= 1'b0;
`endif
      // A set attempt (accepted or rejected) owns the edge: no tick is applied.
      if (bus.set_valid) begin
        if (set_ok) begin
          presc   <= '0;
          year_q  <= bus.set_year;
          month_q <= bus.set_month;
          day_q   <= bus.set_day;
          hour_q  <= bus.set_hour;
          min_q   <= bus.set_minute;
          sec_q   <= bus.set_second;
          week_q  <= bus.set_week;
          ack_q   <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else if (tick) begin
        presc   <= '0;
        year_q  <= n_year;
        month_q <= n_month;
        day_q   <= n_day;
        hour_q  <= n_hour;
        min_q   <= n_min;
        sec_q   <= n_sec;
        week_q  <= n_week;
        sec_p   <= 1'b1;
        min_p   <= min_wrap;
        day_p   <= day_wrap;
`ifdef CALENDAR_RTC_ALARM_EN
        alarm_q <= alarm_hit;
`endif
      end else if (bus.run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign bus.set_ack   = ack_q;
  assign bus.set_err   = err_q;
  assign bus.year      = year_q;
  assign bus.month     = month_q;
  assign bus.day       = day_q;
  assign bus.hour      = hour_q;
  assign bus.minute    = min_q;
  assign bus.second    = sec_q;
  assign bus.week      = week_q;
  assign bus.sec_pulse = sec_p;
  assign bus.min_pulse = min_p;
  assign bus.day_pulse = day_p;
endmodule

// File: tb/tb_calendar_rtc.sv
// tb_calendar_rtc: drives a TICK_DIV=1 and a TICK_DIV=4 calendar_rtc with the same
// stimulus and compares both against a seconds-of-day + date reference model.
module tb_calendar_rtc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calendar_rtc_if b1 ();
  calendar_rtc_if b4 ();
  calendar_rtc #(.TICK_DIV(1)) dut1 (.secclk(clk), .rst(rst), .bus(b1.slave));
  calendar_rtc #(.TICK_DIV(4)) dut4 (.secclk(clk), .rst(rst), .bus(b4.slave));

  typedef struct packed {
    int y, mo, d, w, sod, cnt;
    bit ack, err, sp, mp, dp, al;
  } mdl_t;

  mdl_t m1, m4;
  int   checks = 0, errors = 0;
  int   s_y, s_mo, s_d, s_h, s_mi, s_s, s_w, al_h, al_m;
  bit   s_v, s_run;

  function automatic int dim(int y, int mo);
    bit leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic bit valid_set();
    return s_y >= 1 && s_y <= 9999 && s_mo >= 1 && s_mo <= 12 && s_d >= 1 &&
           s_d <= dim(s_y, s_mo) && s_h <= 23 && s_mi <= 59 && s_s <= 59 &&
           s_w >= 1 && s_w <= 7;
  endfunction

  function automatic mdl_t reset_model();
    mdl_t m;
    m = '0;
    m.y = 2023; m.mo = 5; m.d = 9; m.w = 2;
    return m;
  endfunction

  // One clock edge of the calendar as described at the seconds-of-day level.
  function automatic mdl_t step(mdl_t m, int div);
    m.ack = 0; m.err = 0; m.sp = 0; m.mp = 0; m.dp = 0; m.al = 0;
    if (s_v) begin
      if (valid_set()) begin
        m.y = s_y; m.mo = s_mo; m.d = s_d; m.w = s_w;
        m.sod = s_h * 3600 + s_mi * 60 + s_s;
        m.cnt = 0; m.ack = 1;
      end else m.err = 1;
    end else if (s_run) begin
      if (m.cnt == div - 1) begin
        m.cnt = 0;
        m.sp  = 1;
        m.mp  = (m.sod % 60 == 59);
        m.dp  = (m.sod == 86399);
        m.sod = (m.sod + 1) % 86400;
        if (m.dp) begin
          m.w = m.w % 7 + 1;
          m.d++;
          if (m.d > dim(m.y, m.mo)) begin
            m.d = 1;
            m.mo++;
            if (m.mo > 12) begin
              m.mo = 1;
              m.y  = (m.y == 9999) ? 1 : m.y + 1;
            end
          end
        end
        m.al = (al_h < 24) && (al_m < 60) && (m.sod == al_h * 3600 + al_m * 60);
      end else m.cnt++;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    logic [31:0] e;
    e = exp;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic chk_set(input string who, input logic [15:0] y, input logic [3:0] mo,
                         input logic [4:0] d, input logic [4:0] h, input logic [5:0] mi,
                         input logic [5:0] s, input logic [2:0] w, input logic ack,
                         input logic err, input logic sp, input logic mp, input logic dp,
                         input logic al, input mdl_t m);
    chk({who, ".year"}, 32'(y), m.y);
    chk({who, ".month"}, 32'(mo), m.mo);
    chk({who, ".day"}, 32'(d), m.d);
    chk({who, ".hour"}, 32'(h), m.sod / 3600);
    chk({who, ".minute"}, 32'(mi), (m.sod / 60) % 60);
    chk({who, ".second"}, 32'(s), m.sod % 60);
    chk({who, ".week"}, 32'(w), m.w);
    chk({who, ".set_ack"}, 32'(ack), int'(m.ack));
    chk({who, ".set_err"}, 32'(err), int'(m.err));
    chk({who, ".sec_pulse"}, 32'(sp), int'(m.sp));
    chk({who, ".min_pulse"}, 32'(mp), int'(m.mp));
    chk({who, ".day_pulse"}, 32'(dp), int'(m.dp));
`ifdef CALENDAR_RTC_ALARM_EN
    chk({who, ".alarm"}, 32'(al), int'(m.al));
`else
    if (al) chk({who, ".alarm"}, 32'(al), 0);
`endif
  endtask

  logic a1, a4;
`ifdef CALENDAR_RTC_ALARM_EN
  assign a1 = b1.alarm;
  assign a4 = b4.alarm;
`else
  assign a1 = 1'b0;
  assign a4 = 1'b0;
`endif

  task automatic check_both();
    chk_set("d1", b1.year, b1.month, b1.day, b1.hour, b1.minute, b1.second, b1.week,
            b1.set_ack, b1.set_err, b1.sec_pulse, b1.min_pulse, b1.day_pulse, a1, m1);
    chk_set("d4", b4.year, b4.month, b4.day, b4.hour, b4.minute, b4.second, b4.week,
            b4.set_ack, b4.set_err, b4.sec_pulse, b4.min_pulse, b4.day_pulse, a4, m4);
  endtask

  task automatic drive();
    b1.run = s_run; b1.set_valid = s_v;
    b1.set_year = 16'(s_y); b1.set_month = 4'(s_mo); b1.set_day = 5'(s_d);
    b1.set_hour = 5'(s_h); b1.set_minute = 6'(s_mi); b1.set_second = 6'(s_s);
    b1.set_week = 3'(s_w);
    b4.run = s_run; b4.set_valid = s_v;
    b4.set_year = 16'(s_y); b4.set_month = 4'(s_mo); b4.set_day = 5'(s_d);
    b4.set_hour = 5'(s_h); b4.set_minute = 6'(s_mi); b4.set_second = 6'(s_s);
    b4.set_week = 3'(s_w);
`ifdef CALENDAR_RTC_ALARM_EN
    b1.alarm_hour = 5'(al_h); b1.alarm_minute = 6'(al_m);
    b4.alarm_hour = 5'(al_h); b4.alarm_minute = 6'(al_m);
`endif
  endtask

  task automatic edge_step();
    drive();
    @(posedge clk);
    m1 = step(m1, 1);
    m4 = step(m4, 4);
    #1;
    check_both();
  endtask

  task automatic do_set(input int y, input int mo, input int d, input int h,
                        input int mi, input int s, input int w);
    s_v = 1; s_y = y; s_mo = mo; s_d = d; s_h = h; s_mi = mi; s_s = s; s_w = w;
    edge_step();
    s_v = 0;
  endtask

  initial begin
    bit [19:0] pat;
    int        n_al;
    rst = 1'b1; s_v = 0; s_run = 1;
    s_y = 0; s_mo = 0; s_d = 0; s_h = 0; s_mi = 0; s_s = 0; s_w = 0;
    al_h = 7; al_m = 30;
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m1 = reset_model();
    m4 = reset_model();
    check_both();
    edge_step();
    chk("first_tick_second", 32'(b1.second), 1);

    // Year rollover from Sunday night.
    do_set(2023, 12, 31, 23, 59, 59, 7);
    edge_step();
    chk("newyear_year", 32'(b1.year), 2024);
    chk("newyear_week", 32'(b1.week), 1);
    edge_step();

    // Leap-year boundaries and the year 9999 wrap.
    do_set(2024, 2, 28, 23, 59, 59, 3); edge_step();
    chk("leap2024_day", 32'(b1.day), 29);
    do_set(2100, 2, 28, 23, 59, 59, 7); edge_step();
    chk("nonleap2100_month", 32'(b1.month), 3);
    do_set(2000, 2, 28, 23, 59, 59, 1); edge_step();
    chk("leap2000_day", 32'(b1.day), 29);
    do_set(2023, 2, 28, 23, 59, 59, 2); edge_step();
    do_set(2023, 4, 30, 23, 59, 59, 7); edge_step();
    do_set(9999, 12, 31, 23, 59, 59, 5); edge_step();
    chk("y9999_wrap", 32'(b1.year), 1);

    // Rejected sets, with time held so only the set attempt can change state.
    s_run = 0;
    do_set(2023, 2, 29, 10, 0, 0, 3);
    do_set(2023, 5, 9, 24, 0, 0, 2);
    do_set(0, 5, 9, 1, 0, 0, 2);
    do_set(2023, 13, 9, 1, 0, 0, 2);
    do_set(2023, 6, 31, 1, 0, 0, 2);
    do_set(2023, 6, 0, 1, 0, 0, 2);
    do_set(2023, 6, 1, 1, 60, 0, 2);
    do_set(2023, 6, 1, 1, 0, 60, 2);
    do_set(2023, 6, 1, 1, 0, 0, 0);
    do_set(2024, 2, 29, 12, 0, 0, 4);
    s_run = 1;

    // set_valid held three cycles: three acks, time pinned.
    s_v = 1; s_y = 2022; s_mo = 8; s_d = 15; s_h = 6; s_mi = 5; s_s = 4; s_w = 1;
    repeat (3) edge_step();
    s_v = 0;

    // Run toggling against the divide-by-4 prescaler.
    do_set(2023, 5, 9, 10, 20, 30, 2);
    pat = 20'b1111_1100_0111_1000_1111;
    for (int i = 0; i < 20; i++) begin
      s_run = pat[i];
      edge_step();
    end
    s_run = 1;

    // Set landing on the edge where the divide-by-4 DUT would tick.
    do_set(2023, 5, 9, 10, 20, 30, 2);
    repeat (3) edge_step();
    do_set(2023, 1, 1, 0, 0, 0, 7);
    chk("set_wins_sec_pulse", 32'(b4.sec_pulse), 0);
    chk("set_wins_second", 32'(b4.second), 0);

`ifdef CALENDAR_RTC_ALARM_EN
    al_h = 7; al_m = 30; n_al = 0;
    do_set(2023, 5, 9, 7, 29, 57, 2);
    for (int i = 0; i < 6; i++) begin
      edge_step();
      n_al += int'(b1.alarm);
    end
    chk("alarm_once", 32'(n_al), 1);
    do_set(2023, 5, 9, 7, 30, 0, 2);
    chk("alarm_not_on_set", 32'(b1.alarm), 0);
`else
    n_al = 0;
`endif

    // Randomised traffic biased toward carry boundaries.
    for (int i = 0; i < 400; i++) begin
      s_run = ($urandom % 8) != 0;
      s_v   = ($urandom % 6) == 0;
      if (s_v) begin
        if ($urandom % 2) begin
          case ($urandom % 8)
            0: s_y = 1;    1: s_y = 4;    2: s_y = 100;  3: s_y = 400;
            4: s_y = 2024; 5: s_y = 2100; 6: s_y = 9999; default: s_y = $urandom_range(1, 9999);
          endcase
          s_mo = $urandom_range(1, 12); s_d = $urandom_range(27, 31);
          s_h = $urandom_range(22, 23); s_mi = $urandom_range(58, 59);
          s_s = $urandom_range(50, 59); s_w = $urandom_range(1, 7);
        end else begin
          s_y = $urandom % 65536; s_mo = $urandom % 16; s_d = $urandom % 32;
          s_h = $urandom % 32; s_mi = $urandom % 64; s_s = $urandom % 64; s_w = $urandom % 8;
        end
        if (!valid_set()) s_run = 0;
      end
`ifdef CALENDAR_RTC_ALARM_EN
      if (i % 50 == 0) begin al_h = $urandom % 32; al_m = $urandom % 64; end
`endif
      edge_step();
    end
    s_v = 0; s_run = 1;

    // Reset asserted while a valid set is pending: no ack, reset values.
    s_v = 1; s_y = 2030; s_mo = 3; s_d = 3; s_h = 3; s_mi = 3; s_s = 3; s_w = 3;
    drive();
    @(negedge clk);
    rst = 1'b1;
    #1;
    m1 = reset_model();
    m4 = reset_model();
    check_both();
    @(posedge clk);
    #1;
    check_both();
    @(negedge clk);
    rst = 1'b0;
    s_v = 0;
    edge_step();
    edge_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
